fetch_sequencer: RTL and testbench

- Control state machine that sequences the program counter block. It drives its ps (HOLD/INC/ABS) and pc_in inputs and issues instruction-stream reads to synchronous memory.
- Runs the reset-vector fetch ($FFFC/$FFFD), opcode fetch, operand fetch and jumps.
- Captures opcode and operands for the downstream execute logic.
- Supports NOP ($EA, 1 byte), LDA #imm ($A9, 2 bytes), LDA abs ($AD, 3 bytes) and JMP abs ($4C, 3 bytes). Every other opcode is treated as a 1-byte illegal instruction.

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the reset vector, fetches opcodes and operands
// over a 1-cycle-latency memory and steers the program counter (HOLD/INC/ABS).
package fetch_sequencer_pkg;
  typedef logic [15:0] addr_t;
  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_ABS  = 2'b10
  } ps_t;
endpackage

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter addr_t RST_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  addr_t       pc,
  output ps_t         ps,
  output addr_t       pc_load,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  ir,
  output logic [7:0]  op_lo,
  output logic [7:0]  op_hi,
  output logic        instr_valid,
  output logic        illegal
);

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_JMP     = 8'h4C;

  typedef enum logic [2:0] {
    S_RV_LO  = 3'd0,
    S_RV_HI  = 3'd1,
    S_RV_LD  = 3'd2,
    S_FETCH  = 3'd3,
    S_DECODE = 3'd4,
    S_OPER1  = 3'd5,
    S_OPER2  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] op_lo_q, op_lo_d;
  logic [7:0] op_hi_q, op_hi_d;
  logic [7:0] vec_lo_q, vec_lo_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_RV_LO;
      ir_q     <= '0;
      op_lo_q  <= '0;
      op_hi_q  <= '0;
      vec_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      op_lo_q  <= op_lo_d;
      op_hi_q  <= op_hi_d;
      vec_lo_q <= vec_lo_d;
    end
  end

  // Outputs are forced idle while rst is low, regardless of the state register.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    op_lo_d     = op_lo_q;
    op_hi_d     = op_hi_q;
    vec_lo_d    = vec_lo_q;
    ps          = PS_HOLD;
    pc_load     = '0;
    mem_addr    = '0;
    mem_rd      = 1'b0;
    instr_valid = 1'b0;
    illegal     = 1'b0;
    if (rst) begin
      case (state_q)
        S_RV_LO: begin
          mem_addr = RST_VEC;
          mem_rd   = 1'b1;
          state_d  = S_RV_HI;
        end
        S_RV_HI: begin
          mem_addr = RST_VEC + 16'd1;
          mem_rd   = 1'b1;
          vec_lo_d = mem_data;
          state_d  = S_RV_LD;
        end
        S_RV_LD: begin
          pc_load = {mem_data, vec_lo_q};
          ps      = PS_ABS;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (rdy) begin
            mem_addr = pc;
            mem_rd   = 1'b1;
            ps       = PS_INC;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          ir_d = mem_data;
          case (mem_data)
            OP_LDA_IMM, OP_LDA_ABS, OP_JMP: begin
              mem_addr = pc;
              mem_rd   = 1'b1;
              ps       = PS_INC;
              state_d  = S_OPER1;
            end
            default: begin
              op_lo_d     = '0;
              op_hi_d     = '0;
              instr_valid = 1'b1;
              illegal     = (mem_data != OP_NOP);
              state_d     = S_FETCH;
            end
          endcase
        end
        S_OPER1: begin
          op_lo_d = mem_data;
          if (ir_q == OP_LDA_ABS || ir_q == OP_JMP) begin
            mem_addr = pc;
            mem_rd   = 1'b1;
            ps       = PS_INC;
            state_d  = S_OPER2;
          end else begin
            op_hi_d     = '0;
            instr_valid = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_OPER2: begin
          op_hi_d     = mem_data;
          instr_valid = 1'b1;
          state_d     = S_FETCH;
          if (ir_q == OP_JMP) begin
            ps      = PS_ABS;
            pc_load = {mem_data, op_lo_q};
          end
        end
        default: state_d = S_RV_LO;
      endcase
    end
  end

  assign ir    = ir_q;
  assign op_lo = op_lo_q;
  assign op_hi = op_hi_q;

  a_ps_legal: assert property (@(posedge clk) ps inside {PS_HOLD, PS_INC, PS_ABS});

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: models the program counter and a synchronous
// 1-cycle-latency memory, then checks cycle-by-cycle against hand-derived values.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  addr_t       pc_m = 16'h0000;
  ps_t         ps;
  addr_t       pc_load;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  ir, op_lo, op_hi;
  logic        instr_valid, illegal;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RST_VEC(16'hFFFC)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .pc(pc_m), .ps(ps), .pc_load(pc_load),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .ir(ir), .op_lo(op_lo), .op_hi(op_hi),
    .instr_valid(instr_valid), .illegal(illegal)
  );

  // Program counter and memory reference models
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
    case (ps)
      PS_INC:  pc_m <= pc_m + 16'd1;
      PS_ABS:  pc_m <= pc_load;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
  endtask

  // Reset, vector fetch, ending in the first FETCH cycle with pc = $8000
  task automatic do_reset();
    rst = 1'b0;
    rdy = 1'b1;
    step();
    step();
    check("rst_ps", ps, PS_HOLD);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_pc_load", pc_load, 16'h0000);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_ir", ir, 8'h00);
    rst = 1'b1;
    #1;
    check("rvlo_addr", mem_addr, 16'hFFFC);
    check("rvlo_rd", mem_rd, 1'b1);
    step();
    check("rvhi_addr", mem_addr, 16'hFFFD);
    check("rvhi_rd", mem_rd, 1'b1);
    step();
    check("rvld_ps", ps, PS_ABS);
    check("rvld_pc_load", pc_load, 16'h8000);
    step();
    check("fetch0_pc", pc_m, 16'h8000);
    check("fetch0_addr", mem_addr, 16'h8000);
    check("fetch0_ps", ps, PS_INC);
  endtask

  initial begin
    // Test 1 + 2: reset vector, NOP stream
    clear_mem();
    do_reset();
    step();
    check("nop1_valid", instr_valid, 1'b1);
    check("nop1_illegal", illegal, 1'b0);
    check("nop1_ps", ps, PS_HOLD);
    check("nop1_rd", mem_rd, 1'b0);
    step();
    check("nop1_ir", ir, 8'hEA);
    check("nop2_fetch_pc", pc_m, 16'h8001);
    check("nop2_valid_low", instr_valid, 1'b0);
    step();
    check("nop2_valid", instr_valid, 1'b1);
    step();
    check("nop3_fetch_pc", pc_m, 16'h8002);

    // Test 3: LDA #imm, LDA abs, LDA #imm
    clear_mem();
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55;
    mem[16'h8002] = 8'hAD; mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12;
    mem[16'h8005] = 8'hA9; mem[16'h8006] = 8'h66;
    do_reset();
    step();
    check("ldai_dec_addr", mem_addr, 16'h8001);
    check("ldai_dec_rd", mem_rd, 1'b1);
    check("ldai_dec_valid", instr_valid, 1'b0);
    step();
    check("ldai_op1_valid", instr_valid, 1'b1);
    check("ldai_op1_rd", mem_rd, 1'b0);
    step();
    check("ldai_ir", ir, 8'hA9);
    check("ldai_op_lo", op_lo, 8'h55);
    check("ldai_op_hi", op_hi, 8'h00);
    check("ldaa_fetch_pc", pc_m, 16'h8002);
    step();
    check("ldaa_dec_addr", mem_addr, 16'h8003);
    step();
    check("ldaa_op1_addr", mem_addr, 16'h8004);
    check("ldaa_op1_valid", instr_valid, 1'b0);
    step();
    check("ldaa_op2_valid", instr_valid, 1'b1);
    check("ldaa_op2_ps", ps, PS_HOLD);
    step();
    check("ldaa_ir", ir, 8'hAD);
    check("ldaa_op_lo", op_lo, 8'h34);
    check("ldaa_op_hi", op_hi, 8'h12);
    check("ldaa_next_pc", pc_m, 16'h8005);
    check("ldaa_next_addr", mem_addr, 16'h8005);
    step();
    step();
    check("ldai2_valid", instr_valid, 1'b1);
    step();
    check("ldai2_op_lo", op_lo, 8'h66);
    check("ldai2_op_hi", op_hi, 8'h00);
    check("ldai2_pc", pc_m, 16'h8007);

    // Test 4: JMP abs
    clear_mem();
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h90;
    do_reset();
    step();
    step();
    check("jmp_op1_rd", mem_rd, 1'b1);
    check("jmp_op1_addr", mem_addr, 16'h8002);
    step();
    check("jmp_op2_ps", ps, PS_ABS);
    check("jmp_op2_load", pc_load, 16'h9000);
    check("jmp_op2_valid", instr_valid, 1'b1);
    step();
    check("jmp_fetch_addr", mem_addr, 16'h9000);
    check("jmp_fetch_pc", pc_m, 16'h9000);
    check("jmp_ir", ir, 8'h4C);
    check("jmp_op_hi", op_hi, 8'h90);

    // Test 5: illegal opcode, then rdy stall
    clear_mem();
    mem[16'h8000] = 8'h02;
    do_reset();
    step();
    check("ill_valid", instr_valid, 1'b1);
    check("ill_illegal", illegal, 1'b1);
    check("ill_rd", mem_rd, 1'b0);
    step();
    check("ill_ir", ir, 8'h02);
    check("ill_next_pc", pc_m, 16'h8001);
    rdy = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rd", mem_rd, 1'b0);
      check("stall_ps", ps, PS_HOLD);
      step();
      check("stall_pc", pc_m, 16'h8001);
      check("stall_valid", instr_valid, 1'b0);
    end
    rdy = 1'b1;
    #1;
    check("resume_addr", mem_addr, 16'h8001);
    check("resume_rd", mem_rd, 1'b1);
    check("resume_ps", ps, PS_INC);
    step();
    check("resume_valid", instr_valid, 1'b1);
    check("resume_illegal", illegal, 1'b0);

    // Test 6: straddle $FFFF/$0000, then reset during a JMP
    clear_mem();
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'hFF; mem[16'h8002] = 8'hFF;
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
    mem[16'h0001] = 8'h4C; mem[16'h0002] = 8'h11; mem[16'h0003] = 8'h22;
    do_reset();
    step();
    step();
    step();
    check("wrap_jmp_load", pc_load, 16'hFFFF);
    step();
    check("wrap_fetch_addr", mem_addr, 16'hFFFF);
    step();
    check("wrap_dec_addr", mem_addr, 16'h0000);
    step();
    check("wrap_op1_valid", instr_valid, 1'b1);
    step();
    check("wrap_ir", ir, 8'hA9);
    check("wrap_op_lo", op_lo, 8'h77);
    check("wrap_next_pc", pc_m, 16'h0001);
    step();
    step();
    rst = 1'b0;
    #1;
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_ps", ps, PS_HOLD);
    check("midrst_rd", mem_rd, 1'b0);
    step();
    check("midrst2_valid", instr_valid, 1'b0);
    check("midrst2_ps", ps, PS_HOLD);
    check("midrst_ir_clr", ir, 8'h00);
    check("midrst_op_lo_clr", op_lo, 8'h00);
    rst = 1'b1;
    #1;
    check("restart_addr", mem_addr, 16'hFFFC);
    check("restart_rd", mem_rd, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
